score_topk_list: RTL

Parametrised, self-contained top-K score list: accepts one score/tag pair per handshake, finds its sorted insertion position by sequential compare, shifts the list, and reports the result. Successor to the ranking compare stage: owns the sorted buffer internally rather than taking it as an input, and adds tags, sort-direction selection, eviction reporting and synchronous clear. Sits between the scoring pipeline and the result readout logic.

---
 rtl/score_topk_list.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/score_topk_list.sv
// Sorted top-K score/tag list with a sequential insertion search.
// Accepts one candidate at a time, walks the list one entry per cycle, then shifts it in.
module score_topk_list #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 10,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned DESCEND = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WIDTH-1:0]         in_score_i,
  input  logic [TAG_W-1:0]         in_tag_i,
  output logic                     out_valid_o,
  output logic                     out_inserted_o,
  output logic [IDX_W-1:0]         out_index_o,
  output logic                     out_evict_o,
  output logic [IDX_W-1:0]         count_o,
  output logic [DEPTH*WIDTH-1:0]   list_score_o,
  output logic [DEPTH*TAG_W-1:0]   list_tag_o
);

  typedef enum logic [1:0] {StIdle, StSearch, StInsert, StDone} state_e;

  localparam logic [IDX_W-1:0] DepthIdx = IDX_W'(DEPTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] score_q [DEPTH];
  logic [WIDTH-1:0] score_d [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [TAG_W-1:0] tag_d   [DEPTH];
  logic [WIDTH-1:0] cand_score_q, cand_score_d;
  logic [TAG_W-1:0] cand_tag_q, cand_tag_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;
  logic             out_inserted_q, out_inserted_d;
  logic             out_evict_q, out_evict_d;
  logic [WIDTH-1:0] entry_score;
  logic             cand_better;

  // Entry under the search pointer; reads 0 once ptr walks past the array.
  always_comb begin
    entry_score = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ptr_q == IDX_W'(i)) entry_score = score_q[i];
    end
  end

  // Strict compare keeps equal scores behind existing ones.
  assign cand_better = (DESCEND != 0) ? (cand_score_q > entry_score)
                                      : (cand_score_q < entry_score);

  always_comb begin
    state_d        = state_q;
    score_d        = score_q;
    tag_d          = tag_q;
    cand_score_d   = cand_score_q;
    cand_tag_d     = cand_tag_q;
    ptr_d          = ptr_q;
    idx_d          = idx_q;
    count_d        = count_q;
    out_index_d    = out_index_q;
    out_inserted_d = out_inserted_q;
    out_evict_d    = out_evict_q;

    if (clear_i) begin
      state_d = StIdle;
      count_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        score_d[i] = '0;
        tag_d[i]   = '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            cand_score_d = in_score_i;
            cand_tag_d   = in_tag_i;
            ptr_d        = '0;
            state_d      = StSearch;
          end
        end
        StSearch: begin
          if (ptr_q == count_q) begin
            idx_d   = count_q;
            state_d = StInsert;
          end else if (cand_better) begin
            idx_d   = ptr_q;
            state_d = StInsert;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
        StInsert: begin
          state_d     = StDone;
          out_index_d = idx_q;
          if (idx_q == DepthIdx) begin
            out_inserted_d = 1'b0;
            out_evict_d    = 1'b0;
          end else begin
            out_inserted_d = 1'b1;
            out_evict_d    = (count_q == DepthIdx);
            if (count_q != DepthIdx) count_d = count_q + 1'b1;
            for (int unsigned i = 1; i < DEPTH; i++) begin
              if (IDX_W'(i) > idx_q) begin
                score_d[i] = score_q[i-1];
                tag_d[i]   = tag_q[i-1];
              end
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
              if (IDX_W'(i) == idx_q) begin
                score_d[i] = cand_score_q;
                tag_d[i]   = cand_tag_q;
              end
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      score_q        <= '{default: '0};
      tag_q          <= '{default: '0};
      cand_score_q   <= '0;
      cand_tag_q     <= '0;
      ptr_q          <= '0;
      idx_q          <= '0;
      count_q        <= '0;
      out_index_q    <= '0;
      out_inserted_q <= 1'b0;
      out_evict_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      score_q        <= score_d;
      tag_q          <= tag_d;
      cand_score_q   <= cand_score_d;
      cand_tag_q     <= cand_tag_d;
      ptr_q          <= ptr_d;
      idx_q          <= idx_d;
      count_q        <= count_d;
      out_index_q    <= out_index_d;
      out_inserted_q <= out_inserted_d;
      out_evict_q    <= out_evict_d;
    end
  end

  assign in_ready_o     = (state_q == StIdle) && !clear_i;
  assign out_valid_o    = (state_q == StDone);
  assign out_inserted_o = out_inserted_q;
  assign out_index_o    = out_index_q;
  assign out_evict_o    = out_evict_q;
  assign count_o        = count_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign list_score_o[(g+1)*WIDTH-1 -: WIDTH] = score_q[g];
    assign list_tag_o[(g+1)*TAG_W-1 -: TAG_W]   = tag_q[g];
  end

endmodule
